iddmm_q_gen: RTL and testbench

Parametrised quotient-digit generator for the IDDMM Montgomery multiplier. Each outer iteration i computes q_i = ((a0 + x_i·y0) mod 2^K)·p1 mod 2^K, where p1 = −m⁻¹ mod 2^K. It shares one pipelined low-half multiplier between both products and exposes valid/ready handshakes on input and output. It replaces the free-running q-update path: the controller feeds one (x_i, a0) pair per iteration and consumes the q digit for the rest of the inner loop.

---
 rtl/iddmm_pkg.sv | 24 ++
 rtl/iddmm_mul_lo.sv | 49 ++++
 rtl/iddmm_q_gen.sv | 169 ++++++++++++++++
 tb/tb_iddmm_q_gen.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iddmm_pkg.sv
// +----------------------------------------------------------------------+
// | iddmm_pkg                                                            |
// | Shared types and constants for the IDDMM quotient-digit generator.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package iddmm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_IN = 3'd1,
    ST_MUL1    = 3'd2,
    ST_SUM     = 3'd3,
    ST_MUL2    = 3'd4,
    ST_OUT     = 3'd5,
    ST_DONE    = 3'd6
  } iddmm_qg_state_t;

  localparam int IDDMM_MUL_LAT = 4;

endpackage

`default_nettype wire

// File: rtl/iddmm_mul_lo.sv
// +----------------------------------------------------------------------+
// | iddmm_mul_lo                                                         |
// | Pipelined low-half multiplier: p = (a * b) mod 2^K, MUL_LAT cycles.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module iddmm_mul_lo #(
  parameter int K       = 128,
  parameter int MUL_LAT = 4
) (
  input  logic         clk,
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  output logic [K-1:0] p
);

  logic [K-1:0] r_a;
  logic [K-1:0] r_b;
  logic [K-1:0] w_prod;

  always_ff @(posedge clk) begin
    r_a <= a;
    r_b <= b;
  end

  // Operand registers are the first stage; the remaining stages delay the product.
  assign w_prod = r_a * r_b;

  generate
    if (MUL_LAT == 1) begin : g_direct
      assign p = w_prod;
    end else begin : g_pipe
      logic [K-1:0] r_pipe [MUL_LAT-1];

      always_ff @(posedge clk) begin
        r_pipe[0] <= w_prod;
        for (int i = 1; i < MUL_LAT - 1; i++) begin
          r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign p = r_pipe[MUL_LAT-2];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/iddmm_q_gen.sv
// +----------------------------------------------------------------------+
// | iddmm_q_gen                                                          |
// | IDDMM quotient digit q_i = ((a0 + x_i*y0) mod 2^K) * p1 mod 2^K.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module iddmm_q_gen
  import iddmm_pkg::*;
#(
  parameter int K       = 128,
  parameter int N       = 32,
  parameter int MUL_LAT = IDDMM_MUL_LAT,
  parameter int ADDR_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [K-1:0]      p1,
  input  logic [K-1:0]      y0,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K-1:0]      in_x,
  input  logic [K-1:0]      in_a0,
  output logic              q_valid,
  input  logic              q_ready,
  output logic [K-1:0]      q_data,
  output logic [ADDR_W-1:0] q_idx,
  output logic              busy,
  output logic              done
);

  localparam int                c_CYC_W    = $clog2(MUL_LAT + 1);
  localparam logic [c_CYC_W-1:0] c_CYC_LAST = c_CYC_W'(MUL_LAT - 1);
  localparam logic [ADDR_W-1:0]  c_IDX_LAST = ADDR_W'(N - 1);

  iddmm_qg_state_t     r_state;
  iddmm_qg_state_t     w_next;
  logic [c_CYC_W-1:0]  r_cyc;
  logic [ADDR_W-1:0]   r_idx;
  logic [K-1:0]        r_p1;
  logic [K-1:0]        r_y0;
  logic [K-1:0]        r_x;
  logic [K-1:0]        r_a0;
  logic [K-1:0]        r_s;
  logic [K-1:0]        r_q;
  logic [K-1:0]        w_sum;
  logic [K-1:0]        w_mul_a;
  logic [K-1:0]        w_mul_b;
  logic [K-1:0]        w_mul_out;
  logic                w_mul_done;

  assign w_mul_done = (r_cyc == c_CYC_LAST);
  assign w_sum      = r_a0 + w_mul_out;

  // s is fed straight into the multiplier during SUM so the second product
  // is ready in the last MUL2 cycle, letting q be latched on the MUL2 exit edge.
  always_comb begin
    w_mul_a = r_x;
    w_mul_b = r_y0;
    case (r_state)
      ST_SUM: begin
        w_mul_a = w_sum;
        w_mul_b = r_p1;
      end
      ST_MUL2: begin
        w_mul_a = r_s;
        w_mul_b = r_p1;
      end
      default: begin
        w_mul_a = r_x;
        w_mul_b = r_y0;
      end
    endcase
  end

  iddmm_mul_lo #(
    .K       (K),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk (clk),
    .a   (w_mul_a),
    .b   (w_mul_b),
    .p   (w_mul_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (start)      w_next = ST_WAIT_IN;
      ST_WAIT_IN: if (in_valid)   w_next = ST_MUL1;
      ST_MUL1:    if (w_mul_done) w_next = ST_SUM;
      ST_SUM:                     w_next = ST_MUL2;
      ST_MUL2:    if (w_mul_done) w_next = ST_OUT;
      ST_OUT: begin
        if (q_ready) begin
          w_next = (r_idx == c_IDX_LAST) ? ST_DONE : ST_WAIT_IN;
        end
      end
      ST_DONE:                    w_next = ST_IDLE;
      default:                    w_next = ST_IDLE;
    endcase
    if (abort) begin
      w_next = ST_IDLE;
    end
  end

  always_comb begin
    in_ready = (r_state == ST_WAIT_IN);
    q_valid  = (r_state == ST_OUT) && !abort;
    busy     = (r_state != ST_IDLE);
    done     = (r_state == ST_DONE) && !abort;
  end

  assign q_data = r_q;
  assign q_idx  = r_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cyc <= '0;
      r_idx <= '0;
      r_q   <= '0;
    end else begin
      if ((r_state == ST_MUL1 || r_state == ST_MUL2) && !w_mul_done) begin
        r_cyc <= r_cyc + 1'b1;
      end else begin
        r_cyc <= '0;
      end

      if (abort) begin
        r_idx <= '0;
      end else if (r_state == ST_IDLE && start) begin
        r_idx <= '0;
      end else if (r_state == ST_OUT && q_ready && r_idx != c_IDX_LAST) begin
        r_idx <= r_idx + 1'b1;
      end

      if (r_state == ST_MUL2 && w_mul_done && !abort) begin
        r_q <= w_mul_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && start) begin
      r_p1 <= p1;
      r_y0 <= y0;
    end
    if (r_state == ST_WAIT_IN && in_valid) begin
      r_x  <= in_x;
      r_a0 <= in_a0;
    end
    if (r_state == ST_SUM) begin
      r_s <= w_sum;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iddmm_q_gen.sv
// +----------------------------------------------------------------------+
// | tb_iddmm_q_gen                                                       |
// | Directed/table bench for iddmm_q_gen (K=8, MUL_LAT=4, N=4 and N=1).  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_iddmm_q_gen;

  localparam int K = 8;
  localparam int L = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start, abort, in_valid, q_ready;
  logic [7:0] p1, y0, in_x, in_a0;
  logic       in_ready, q_valid, busy, done;
  logic [7:0] q_data;
  logic [1:0] q_idx;

  logic       b_start, b_abort, b_in_valid, b_q_ready;
  logic [7:0] b_p1, b_y0, b_in_x, b_in_a0;
  logic       b_in_ready, b_q_valid, b_busy, b_done;
  logic [7:0] b_q_data;
  logic [0:0] b_q_idx;

  iddmm_q_gen #(.K(K), .N(4), .MUL_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .p1(p1), .y0(y0), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_a0(in_a0),
    .q_valid(q_valid), .q_ready(q_ready), .q_data(q_data), .q_idx(q_idx),
    .busy(busy), .done(done)
  );

  iddmm_q_gen #(.K(K), .N(1), .MUL_LAT(L)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .p1(b_p1), .y0(b_y0), .abort(b_abort),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_x(b_in_x), .in_a0(b_in_a0),
    .q_valid(b_q_valid), .q_ready(b_q_ready), .q_data(b_q_data), .q_idx(b_q_idx),
    .busy(b_busy), .done(b_done)
  );

  typedef struct {
    logic [7:0] p1;
    logic [7:0] y0;
    logic [7:0] x;
    logic [7:0] a0;
    logic [7:0] q;
  } vec_t;

  vec_t tbl [8];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cnt = 0;
  int   qv_cnt   = 0;

  always @(negedge clk) begin
    if (done === 1'b1)    done_cnt++;
    if (q_valid === 1'b1) qv_cnt++;
  end

  function automatic logic [7:0] ref_q(input logic [7:0] pv, input logic [7:0] yv,
                                       input logic [7:0] xv, input logic [7:0] av);
    logic [7:0] prod;
    logic [7:0] s;
    logic [7:0] q;
    prod = xv * yv;
    s    = av + prod;
    q    = s * pv;
    return q;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [7:0] pv, input logic [7:0] yv);
    start = 1'b1;
    p1    = pv;
    y0    = yv;
    step();
    start = 1'b0;
    p1    = 8'($urandom);
    y0    = 8'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic send(input logic [7:0] xv, input logic [7:0] av, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) step();
    in_x     = xv;
    in_a0    = av;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) check("in_ready_timeout", 32'(t), 32'd0);
    step();
    in_valid = 1'b0;
    in_x     = 8'($urandom);
    in_a0    = 8'($urandom);
  endtask

  task automatic recv(input logic [7:0] exp_q, input logic [1:0] exp_idx, input int stall);
    int t;
    t = 0;
    while (!q_valid && t < 100) begin
      step();
      t++;
    end
    check("q_latency", 32'(t), 32'(2 * L + 1));
    repeat (stall) begin
      step();
      check("q_stable_valid", 32'(q_valid), 32'd1);
      check("q_stable_data", 32'(q_data), 32'(exp_q));
    end
    check("q_data", 32'(q_data), 32'(exp_q));
    check("q_idx", 32'(q_idx), 32'(exp_idx));
    q_ready = 1'b1;
    step();
    q_ready = 1'b0;
  endtask

  task automatic finish_run(input int d0);
    check("done_pulse", 32'(done), 32'd1);
    step();
    check("done_low", 32'(done), 32'd0);
    check("busy_low", 32'(busy), 32'd0);
    check("done_count", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0, q0, t;
    logic [7:0] rp, ry, rx, ra;

    // Hand-computed vectors: groups of four share p1/y0
    tbl[0] = '{8'd11, 8'd5, 8'h03, 8'h07, 8'hF2};
    tbl[1] = '{8'd11, 8'd5, 8'h10, 8'h20, 8'hD0};
    tbl[2] = '{8'd11, 8'd5, 8'hFF, 8'h01, 8'hD4};
    tbl[3] = '{8'd11, 8'd5, 8'h00, 8'hAB, 8'h59};
    tbl[4] = '{8'h80, 8'hFF, 8'hFF, 8'h01, 8'h00};
    tbl[5] = '{8'h80, 8'hFF, 8'h01, 8'h00, 8'h80};
    tbl[6] = '{8'h80, 8'hFF, 8'h02, 8'h03, 8'h80};
    tbl[7] = '{8'h80, 8'hFF, 8'h00, 8'h00, 8'h00};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; q_ready = 1'b0;
    p1 = '0; y0 = '0; in_x = '0; in_a0 = '0;
    b_start = 1'b0; b_abort = 1'b0; b_in_valid = 1'b0; b_q_ready = 1'b0;
    b_p1 = '0; b_y0 = '0; b_in_x = '0; b_in_a0 = '0;
    repeat (3) step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_q_valid", 32'(q_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q_data", 32'(q_data), 32'd0);
    check("rst_q_idx", 32'(q_idx), 32'd0);
    rst_n = 1'b1;
    step();

    // Table-driven runs; run 0 also pulses start with a new p1 during WAIT_IN
    for (int r = 0; r < 2; r++) begin
      d0 = done_cnt;
      start_run(tbl[r*4].p1, tbl[r*4].y0);
      for (int i = 0; i < 4; i++) begin
        if (r == 0 && i == 1) begin
          check("in_ready_wait", 32'(in_ready), 32'd1);
          start = 1'b1;
          p1    = 8'h33;
          step();
          start = 1'b0;
        end
        send(tbl[r*4+i].x, tbl[r*4+i].a0, i);
        recv(tbl[r*4+i].q, 2'(i), i % 3);
      end
      finish_run(d0);
    end

    // Abort during MUL2
    d0 = done_cnt;
    start_run(8'd11, 8'd5);
    send(8'h03, 8'h07, 0);
    repeat (6) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_q_idx", 32'(q_idx), 32'd0);
    q0 = qv_cnt;
    repeat (15) step();
    check("abort_no_q_valid", 32'(qv_cnt - q0), 32'd0);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // Clean randomised run after abort, with input gaps and output stalls
    d0 = done_cnt;
    rp = 8'($urandom);
    ry = 8'($urandom);
    start_run(rp, ry);
    for (int i = 0; i < 4; i++) begin
      rx = 8'($urandom);
      ra = 8'($urandom);
      send(rx, ra, $urandom_range(0, 3));
      recv(ref_q(rp, ry, rx, ra), 2'(i), $urandom_range(0, 4));
    end
    finish_run(d0);

    // Reset for one edge while in OUT
    start_run(8'd11, 8'd5);
    send(8'h10, 8'h20, 0);
    t = 0;
    while (!q_valid && t < 100) begin
      step();
      t++;
    end
    check("pre_reset_q_valid", 32'(q_valid), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("out_rst_q_valid", 32'(q_valid), 32'd0);
    check("out_rst_busy", 32'(busy), 32'd0);
    check("out_rst_in_ready", 32'(in_ready), 32'd0);
    check("out_rst_done", 32'(done), 32'd0);
    check("out_rst_q_data", 32'(q_data), 32'd0);
    check("out_rst_q_idx", 32'(q_idx), 32'd0);
    step();

    // N=1 instance: one iteration then DONE
    b_start = 1'b1; b_p1 = 8'd11; b_y0 = 8'd5;
    step();
    b_start = 1'b0; b_p1 = 8'h5A; b_y0 = 8'hC3;
    b_in_x = 8'h03; b_in_a0 = 8'h07; b_in_valid = 1'b1;
    t = 0;
    while (!b_in_ready && t < 100) begin
      step();
      t++;
    end
    step();
    b_in_valid = 1'b0;
    t = 0;
    while (!b_q_valid && t < 100) begin
      step();
      t++;
    end
    check("n1_latency", 32'(t), 32'(2 * L + 1));
    check("n1_q_data", 32'(b_q_data), 32'hF2);
    check("n1_q_idx", 32'(b_q_idx), 32'd0);
    b_q_ready = 1'b1;
    step();
    b_q_ready = 1'b0;
    check("n1_done", 32'(b_done), 32'd1);
    step();
    check("n1_done_low", 32'(b_done), 32'd0);
    check("n1_busy_low", 32'(b_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
